// File: rtl/lsu_stage.sv
// lsu_stage: memory-access stage between exe and writeback.
// One op in flight at a time over an aligned 8-byte valid/ready data bus.
module lsu_stage #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic              wb_valid,
    output logic              wb_wen,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              misalign_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_e;

    state_e            state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              ld_q, ld_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              req_we_q, req_we_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [7:0]        req_wmask_q, req_wmask_d;
    logic              wb_wen_q, wb_wen_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              is_ld, is_st, misal;
    logic [7:0]        lanes;
    logic [DATA_W-1:0] sh, ext;

    // both flags set is treated as a load
    assign is_ld = in_is_load;
    assign is_st = in_is_store & ~in_is_load;

    always_comb begin
        misal = 1'b0;
        lanes = 8'h01;
        unique case (in_size)
            2'b00: begin misal = 1'b0;            lanes = 8'h01; end
            2'b01: begin misal = in_addr[0];      lanes = 8'h03; end
            2'b10: begin misal = |in_addr[1:0];   lanes = 8'h0F; end
            2'b11: begin misal = |in_addr[2:0];   lanes = 8'hFF; end
        endcase
    end

    assign sh = mem_resp_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = sh;
        unique case (size_q)
            2'b00: ext = {{56{~uns_q & sh[7]}}, sh[7:0]};
            2'b01: ext = {{48{~uns_q & sh[15]}}, sh[15:0]};
            2'b10: ext = {{32{~uns_q & sh[31]}}, sh[31:0]};
            2'b11: ext = sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        uns_d       = uns_q;
        err_d       = err_q;
        size_d      = size_q;
        off_d       = off_q;
        rd_d        = rd_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        wb_wen_d    = wb_wen_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        unique case (state_q)
            IDLE: if (in_valid && rdy_q) begin
                ld_d        = is_ld;
                uns_d       = in_unsigned;
                size_d      = in_size;
                off_d       = in_addr[2:0];
                rd_d        = in_rd;
                err_d       = (is_ld | is_st) & misal;
                req_we_d    = is_st;
                req_addr_d  = {in_addr[ADDR_W-1:3], 3'b000};
                req_wmask_d = is_st ? lanes << in_addr[2:0] : 8'h00;
                req_wdata_d = is_st ? in_wdata << {in_addr[2:0], 3'b000} : '0;
                if (!(is_ld || is_st)) begin
                    state_d   = WB;
                    wb_wen_d  = (in_rd != 5'd0);
                    wb_rd_d   = in_rd;
                    wb_data_d = in_alu_result;
                end else if (misal) begin
                    state_d   = WB;
                    wb_wen_d  = 1'b0;
                    wb_rd_d   = in_rd;
                    wb_data_d = '0;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (mem_req_ready) state_d = RESP;
            RESP: if (mem_resp_valid) begin
                state_d   = WB;
                wb_wen_d  = ld_q && (rd_q != 5'd0);
                wb_rd_d   = rd_q;
                wb_data_d = ld_q ? ext : '0;
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            ld_q        <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 3'b000;
            rd_q        <= 5'd0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wmask_q <= 8'h00;
            wb_wen_q    <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            ld_q        <= ld_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            size_q      <= size_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
            wb_wen_q    <= wb_wen_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign in_ready      = rdy_q;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = req_we_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;
    assign wb_valid      = (state_q == WB);
    assign wb_wen        = wb_wen_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign_err  = wb_valid & err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: random and directed ops against a byte-level reference model.
// A negedge monitor compares bus requests and writeback beats to the model.
module tb_lsu_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_load, in_is_store, in_unsigned;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata, in_alu_result;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid, wb_wen, misalign_err;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    lsu_stage #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_result(in_alu_result), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          ld, st, uns;
        bit [1:0]    size;
        logic [63:0] addr, wdata, alu, rdata;
        logic [4:0]  rd;
    } op_t;
    typedef struct {
        logic        wen, err;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;
    typedef struct {
        logic        we;
        logic [63:0] addr, wdata;
        logic [7:0]  mask;
    } req_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic op_t mk(bit ld, bit st, bit [1:0] sz, bit uns,
                               logic [63:0] addr, logic [63:0] wdata,
                               logic [63:0] alu, logic [63:0] rdata,
                               logic [4:0] rd);
        op_t o;
        o.ld = ld; o.st = st; o.size = sz; o.uns = uns;
        o.addr = addr; o.wdata = wdata; o.alu = alu;
        o.rdata = rdata; o.rd = rd;
        return o;
    endfunction

    // reference: pick bytes out of the 8-byte word one at a time
    function automatic wb_t model_wb(op_t o);
        wb_t         e;
        int          n, off;
        bit          isld, mem;
        logic [63:0] v, b;
        isld = o.ld;
        mem = o.ld | o.st;
        n = 1 << o.size;
        off = int'(o.addr % 64'd8);
        e.rd = o.rd;
        e.err = mem && ((off % n) != 0);
        e.data = 64'd0;
        if (!mem) begin
            e.data = o.alu;
        end else if (isld && !e.err) begin
            v = 64'd0;
            for (int i = 0; i < n; i++) begin
                b = (o.rdata >> (8 * (off + i))) & 64'hFF;
                v = v | (b << (8 * i));
            end
            if (!o.uns && n < 8 && v[8*n-1])
                v = v | ~((64'd1 << (8 * n)) - 64'd1);
            e.data = v;
        end
        e.wen = (isld || !mem) && (o.rd != 5'd0) && !e.err;
        return e;
    endfunction

    function automatic req_t model_req(op_t o);
        req_t r;
        int   n, off, m;
        bit   isst;
        isst = o.st && !o.ld;
        n = 1 << o.size;
        off = int'(o.addr % 64'd8);
        m = ((1 << n) - 1) << off;
        r.we = isst;
        r.addr = o.addr - 64'(off);
        r.mask = isst ? 8'(m) : 8'h00;
        r.wdata = isst ? o.wdata << (8 * off) : 64'd0;
        return r;
    endfunction

    wb_t         exp_q[$];
    req_t        exp_req;
    bit          exp_req_on = 0;
    logic        held_wen, last_err;
    logic [4:0]  held_rd;
    logic [63:0] held_data;

    always @(negedge clk) begin
        wb_t e;
        if (!rst) begin
            held_wen = 1'b0;
            held_rd = 5'd0;
            held_data = 64'd0;
            last_err = 1'b0;
        end else begin
            if (mem_req_valid) begin
                check("req_unexpected", 64'(mem_req_valid & ~exp_req_on), 64'd0);
                check("ready_in_req", 64'(in_ready), 64'd0);
                if (exp_req_on) begin
                    check("req_we", 64'(mem_req_we), 64'(exp_req.we));
                    check("req_addr", mem_req_addr, exp_req.addr);
                    check("req_wmask", 64'(mem_req_wmask), 64'(exp_req.mask));
                    check("req_wdata", mem_req_wdata, exp_req.wdata);
                end
            end
            if (wb_valid) begin
                check("ready_in_wb", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    check("wb_unexpected", 64'(wb_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_wen", 64'(wb_wen), 64'(e.wen));
                    check("wb_rd", 64'(wb_rd), 64'(e.rd));
                    check("wb_data", wb_data, e.data);
                    check("wb_err", 64'(misalign_err), 64'(e.err));
                end
                held_wen = wb_wen;
                held_rd = wb_rd;
                held_data = wb_data;
                last_err = misalign_err;
            end else begin
                check("err_no_wb", 64'(misalign_err), 64'd0);
                check("wb_hold", {wb_wen, wb_rd, 58'd0} ^ 64'(wb_data),
                      {held_wen, held_rd, 58'd0} ^ 64'(held_data));
            end
        end
    end

    task automatic run_op(input op_t o, input int w, input int r);
        wb_t  e;
        bit   ok, busmem;
        int   t0, lat;
        e = model_wb(o);
        busmem = (o.ld || o.st) && !e.err;
        in_valid = 1'b1;
        in_is_load = o.ld;
        in_is_store = o.st;
        in_size = o.size;
        in_unsigned = o.uns;
        in_addr = o.addr;
        in_wdata = o.wdata;
        in_alu_result = o.alu;
        in_rd = o.rd;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        exp_req = model_req(o);
        exp_req_on = busmem;
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_is_load = 1'($urandom_range(0, 1));
        in_is_store = 1'($urandom_range(0, 1));
        in_addr = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};
        in_alu_result = {$urandom, $urandom};
        in_rd = 5'($urandom_range(0, 31));
        if (busmem) begin
            for (int k = 0; k < w; k++) begin
                mem_resp_valid = 1'($urandom_range(0, 1));
                mem_resp_rdata = {$urandom, $urandom};
                @(negedge clk);
            end
            mem_req_ready = 1'b1;
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_rdata = {$urandom, $urandom};
            @(negedge clk);
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            exp_req_on = 0;
            for (int k = 0; k < r; k++) @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = o.rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
        end
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (wb_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("wb_timeout", 64'(wb_valid), 64'd1);
            exp_q.delete();
            exp_req_on = 0;
            return;
        end
        lat = busmem ? 3 + w + r : 1;
        check("latency", 64'(cyc - t0), 64'(lat));
        @(negedge clk);
    endtask

    initial begin
        op_t         o;
        wb_t         e;
        req_t        q;
        logic [63:0] am;
        int          kind;

        rst = 1'b0;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_size = 2'b00; in_unsigned = 1'b0;
        in_addr = 64'd0; in_wdata = 64'd0; in_alu_result = 64'd0;
        in_rd = 5'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_flags", {mem_req_valid, wb_valid, wb_wen, misalign_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // model pinned to hand-worked values
        e = model_wb(mk(0, 0, 2'b11, 0, 64'h0, 64'h0, 64'h1234, 64'h0, 5'd5));
        check("pin_nonmem", {e.wen, e.data[62:0]}, {1'b1, 63'h1234});
        e = model_wb(mk(1, 0, 2'b00, 0, 64'h1003, 64'h0, 64'h0,
                        64'h0000_0000_80FF_0000, 5'd7));
        check("pin_lb", e.data, 64'hFFFF_FFFF_FFFF_FF80);
        e = model_wb(mk(1, 0, 2'b00, 1, 64'h1003, 64'h0, 64'h0,
                        64'h0000_0000_80FF_0000, 5'd7));
        check("pin_lbu", e.data, 64'h80);
        q = model_req(mk(0, 1, 2'b01, 0, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 5'd3));
        check("pin_sh_mask", 64'(q.mask), 64'hC0);
        check("pin_sh_wdata", q.wdata, 64'hBEEF_0000_0000_0000);
        e = model_wb(mk(1, 0, 2'b10, 0, 64'h3002, 64'h0, 64'h0, 64'h0, 5'd4));
        check("pin_lw_err", 64'(e.err), 64'd1);

        // directed scenarios through the DUT
        run_op(mk(0, 0, 2'b11, 0, 64'h0, 64'h0, 64'h1234, 64'h0, 5'd5), 0, 0);
        check("t1_data", held_data, 64'h1234);
        run_op(mk(1, 0, 2'b00, 0, 64'h1003, 64'h0, 64'h0,
                  64'h0000_0000_80FF_0000, 5'd7), 0, 0);
        check("t2_lb", held_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(mk(1, 0, 2'b00, 1, 64'h1003, 64'h0, 64'h0,
                  64'h0000_0000_80FF_0000, 5'd7), 0, 0);
        check("t2_lbu", held_data, 64'h80);
        run_op(mk(0, 1, 2'b01, 0, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 5'd3), 0, 0);
        check("t3_sh_wen", 64'(held_wen), 64'd0);
        run_op(mk(1, 0, 2'b11, 0, 64'h4008, 64'h0, 64'h0,
                  64'h0123_4567_89AB_CDEF, 5'd9), 5, 3);
        check("t4_ld", held_data, 64'h0123_4567_89AB_CDEF);
        run_op(mk(1, 0, 2'b10, 0, 64'h3002, 64'h0, 64'h0, 64'h0, 5'd4), 0, 0);
        check("t5_err", 64'(last_err), 64'd1);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 3);
            o.ld = (kind == 1) || (kind == 3);
            o.st = (kind == 2) || (kind == 3);
            o.size = 2'($urandom_range(0, 3));
            o.uns = 1'($urandom_range(0, 1));
            o.addr = {$urandom, $urandom};
            am = (64'd1 << o.size) - 64'd1;
            if ($urandom_range(0, 2) != 0) o.addr = o.addr & ~am;
            o.wdata = {$urandom, $urandom};
            o.alu = {$urandom, $urandom};
            o.rdata = {$urandom, $urandom};
            o.rd = 5'($urandom_range(0, 31));
            run_op(o, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // reset while waiting for the response, then a stray beat
        run_op(mk(0, 0, 2'b00, 0, 64'h0, 64'h0, 64'hAA55, 64'h0, 5'd11), 0, 0);
        o = mk(1, 0, 2'b11, 0, 64'h5000, 64'h0, 64'h0, 64'h0, 5'd12);
        in_valid = 1'b1;
        in_is_load = 1'b1; in_is_store = 1'b0;
        in_size = 2'b11; in_addr = o.addr; in_rd = o.rd;
        exp_req = model_req(o);
        exp_req_on = 1;
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        exp_req_on = 0;
        #2 rst = 1'b0;
        #1;
        check("t6_req", {mem_req_valid, mem_req_we, mem_req_wmask}, 64'd0);
        check("t6_addr", mem_req_addr, 64'd0);
        check("t6_wdata", mem_req_wdata, 64'd0);
        check("t6_wb", {in_ready, wb_valid, wb_wen, wb_rd, misalign_err}, 64'd0);
        check("t6_data", wb_data, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t6_no_wb", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end
        check("t6_ready", 64'(in_ready), 64'd1);
        check("t6_data_after", wb_data, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
